// File: rtl/gshare_update.sv
// Training half of a 16-entry gshare predictor: owns the 2-bit PHT, a shadow
// global history and a FIFO of in-flight prediction indices awaiting resolution.
module gshare_update #(
    parameter int DEPTH = 4,
    parameter int CNTW  = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            brnch,
    input  logic [3:0]      adrs,
    input  logic            res_vld,
    input  logic            res_taken,
    input  logic            clr,
    output logic [15:0]     sram,
    output logic            shft,
    output logic            shin,
    output logic            mispred,
    output logic [CNTW-1:0] mispred_cnt,
    output logic            full,
    output logic            empty,
    output logic            ovf,
    output logic            udf
);

    localparam int PW = $clog2(DEPTH);

    logic [1:0]    pht_reg [16];
    logic [3:0]    ghr_reg;
    logic [4:0]    q_mem [DEPTH];
    logic [PW-1:0] wr_ptr_reg;
    logic [PW-1:0] rd_ptr_reg;
    logic [PW:0]   count_reg;
    logic          mispred_reg;
    logic [CNTW-1:0] mispred_cnt_reg;
    logic          ovf_reg;
    logic          udf_reg;

    logic [3:0] idx;
    logic       pbit;
    logic       push;
    logic       pop;
    logic [3:0] hidx;
    logic       hp;
    logic       miss;

    assign empty = (count_reg == '0);
    assign full  = (count_reg == (PW+1)'(DEPTH));

    // Lookup uses pre-edge history and counters; a same-cycle pop lands at the edge.
    assign idx  = adrs ^ ghr_reg;
    assign pbit = pht_reg[idx][1];

    // A pop frees a slot in the same cycle, so a push into a full queue still fits.
    assign pop  = res_vld & ~empty;
    assign push = brnch & (~full | pop);

    assign hidx = q_mem[rd_ptr_reg][4:1];
    assign hp   = q_mem[rd_ptr_reg][0];
    assign miss = pop & (hp != res_taken);

    assign shft = pop;
    assign shin = res_taken;

    assign mispred     = mispred_reg;
    assign mispred_cnt = mispred_cnt_reg;
    assign ovf         = ovf_reg;
    assign udf         = udf_reg;

    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_pht
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    pht_reg[gi] <= 2'b01;
                end else if (pop && hidx == 4'(gi)) begin
                    if (res_taken) begin
                        if (pht_reg[gi] != 2'b11) pht_reg[gi] <= pht_reg[gi] + 2'b01;
                    end else begin
                        if (pht_reg[gi] != 2'b00) pht_reg[gi] <= pht_reg[gi] - 2'b01;
                    end
                end
            end
            assign sram[gi] = pht_reg[gi][1];
        end
    endgenerate

    // Queue storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) q_mem[wr_ptr_reg] <= {idx, pbit};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ghr_reg    <= '0;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (pop)  ghr_reg    <= {ghr_reg[2:0], res_taken};
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            if (push && !pop)      count_reg <= count_reg + 1'b1;
            else if (pop && !push) count_reg <= count_reg - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mispred_reg     <= 1'b0;
            mispred_cnt_reg <= '0;
            ovf_reg         <= 1'b0;
            udf_reg         <= 1'b0;
        end else begin
            mispred_reg <= miss;
            if (clr)                             mispred_cnt_reg <= '0;
            else if (miss && mispred_cnt_reg != '1) mispred_cnt_reg <= mispred_cnt_reg + 1'b1;
            if (clr)                             ovf_reg <= 1'b0;
            else if (brnch && full && !pop)      ovf_reg <= 1'b1;
            if (clr)                             udf_reg <= 1'b0;
            else if (res_vld && empty)           udf_reg <= 1'b1;
        end
    end

endmodule

// File: tb/tb_gshare_update.sv
// Directed bench for gshare_update: training, saturation, queue limits,
// underflow, counter saturation and asynchronous reset.
module tb_gshare_update;

    logic        clk = 1'b0;
    logic        rst;
    logic        brnch;
    logic [3:0]  adrs;
    logic        res_vld;
    logic        res_taken;
    logic        clr;
    logic [15:0] sram;
    logic        shft;
    logic        shin;
    logic        mispred;
    logic [7:0]  mispred_cnt;
    logic        full;
    logic        empty;
    logic        ovf;
    logic        udf;

    int checks = 0;
    int errors = 0;
    logic [3:0] ghr_m;

    gshare_update #(.DEPTH(4), .CNTW(8)) dut (
        .clk(clk), .rst(rst), .brnch(brnch), .adrs(adrs), .res_vld(res_vld),
        .res_taken(res_taken), .clr(clr), .sram(sram), .shft(shft), .shin(shin),
        .mispred(mispred), .mispred_cnt(mispred_cnt), .full(full), .empty(empty),
        .ovf(ovf), .udf(udf)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset;
        brnch = 0; adrs = 0; res_vld = 0; res_taken = 0; clr = 0;
        rst = 1;
        tick(); tick();
        rst = 0;
        ghr_m = 4'h0;
        tick();
    endtask

    // One prediction followed by its resolution in the next cycle.
    task automatic do_branch(input logic [3:0] a, input logic t, output logic mp, output logic sh);
        brnch = 1; adrs = a;
        tick();
        brnch = 0; res_vld = 1; res_taken = t;
        #1 sh = shft;
        tick();
        res_vld = 0;
        mp = mispred;
        ghr_m = {ghr_m[2:0], t};
    endtask

    task automatic test_reset;
        apply_reset();
        repeat (5) tick();
        checks++; if (sram !== 16'h0000) begin errors++; $display("FAIL reset_sram got %h exp 0000", sram); end
        checks++; if (empty !== 1'b1 || full !== 1'b0) begin errors++; $display("FAIL reset_empty got empty=%b full=%b exp 1 0", empty, full); end
        checks++; if (shft !== 1'b0) begin errors++; $display("FAIL reset_shft got %b exp 0", shft); end
        checks++; if (mispred_cnt !== 8'h00 || mispred !== 1'b0 || ovf !== 1'b0 || udf !== 1'b0)
            begin errors++; $display("FAIL reset_flags got cnt=%h mp=%b ovf=%b udf=%b exp 00 0 0 0", mispred_cnt, mispred, ovf, udf); end
        $display("reset: sram=%h empty=%b cnt=%h", sram, empty, mispred_cnt);
    endtask

    task automatic test_train;
        logic mp, sh;
        logic [15:0] exp_sram [3] = '{16'h0020, 16'h0030, 16'h0070};
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            do_branch(4'h5, 1'b1, mp, sh);
            checks++; if (sram !== exp_sram[i]) begin errors++; $display("FAIL train_sram[%0d] got %h exp %h", i, sram, exp_sram[i]); end
            checks++; if (mp !== 1'b1 || sh !== 1'b1) begin errors++; $display("FAIL train_mp[%0d] got mp=%b shft=%b exp 1 1", i, mp, sh); end
            $display("train %0d: sram=%h mispred=%b", i, sram, mp);
        end
        tick();
        checks++; if (mispred !== 1'b0) begin errors++; $display("FAIL train_mp_pulse got %b exp 0", mispred); end
        checks++; if (mispred_cnt !== 8'd3) begin errors++; $display("FAIL train_cnt got %0d exp 3", mispred_cnt); end
    endtask

    task automatic test_saturation;
        logic mp, sh;
        logic exp_mp [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            do_branch(4'h9 ^ ghr_m, 1'b1, mp, sh);
            checks++; if (mp !== exp_mp[i]) begin errors++; $display("FAIL sat_mp[%0d] got %b exp %b", i, mp, exp_mp[i]); end
            $display("sat taken %0d: sram=%h mispred=%b", i, sram, mp);
        end
        do_branch(4'h9 ^ ghr_m, 1'b0, mp, sh);
        checks++; if (mp !== 1'b1) begin errors++; $display("FAIL sat_nt_mp got %b exp 1", mp); end
        checks++; if (sram !== 16'h0200) begin errors++; $display("FAIL sat_nt_sram got %h exp 0200", sram); end
        $display("sat not-taken: sram=%h mispred=%b", sram, mp);
    endtask

    task automatic test_full;
        logic sh;
        apply_reset();
        brnch = 1; adrs = 4'h0;
        repeat (4) tick();
        checks++; if (full !== 1'b1 || ovf !== 1'b0) begin errors++; $display("FAIL full_after4 got full=%b ovf=%b exp 1 0", full, ovf); end
        tick();
        checks++; if (full !== 1'b1 || ovf !== 1'b1) begin errors++; $display("FAIL full_drop got full=%b ovf=%b exp 1 1", full, ovf); end
        res_vld = 1; res_taken = 0;
        #1 sh = shft;
        tick();
        checks++; if (full !== 1'b1 || ovf !== 1'b1 || sh !== 1'b1) begin errors++; $display("FAIL full_pushpop got full=%b ovf=%b shft=%b exp 1 1 1", full, ovf, sh); end
        brnch = 0; res_vld = 0; clr = 1;
        tick();
        clr = 0;
        checks++; if (ovf !== 1'b0 || full !== 1'b1) begin errors++; $display("FAIL full_clr got ovf=%b full=%b exp 0 1", ovf, full); end
        res_vld = 1;
        repeat (4) tick();
        res_vld = 0;
        checks++; if (empty !== 1'b1 || udf !== 1'b0) begin errors++; $display("FAIL full_drain got empty=%b udf=%b exp 1 0", empty, udf); end
        $display("full: drained empty=%b ovf=%b udf=%b", empty, ovf, udf);
    endtask

    task automatic test_underflow;
        logic mp, sh;
        apply_reset();
        res_vld = 1; res_taken = 1;
        #1 sh = shft;
        tick();
        res_vld = 0;
        checks++; if (sh !== 1'b0) begin errors++; $display("FAIL udf_shft got %b exp 0", sh); end
        checks++; if (udf !== 1'b1 || mispred !== 1'b0 || sram !== 16'h0000)
            begin errors++; $display("FAIL udf_flags got udf=%b mp=%b sram=%h exp 1 0 0000", udf, mispred, sram); end
        do_branch(4'h5, 1'b1, mp, sh);
        checks++; if (sram !== 16'h0020) begin errors++; $display("FAIL udf_ghr_kept got sram=%h exp 0020", sram); end
        apply_reset();
        res_vld = 1; clr = 1;
        tick();
        res_vld = 0; clr = 0;
        checks++; if (udf !== 1'b0) begin errors++; $display("FAIL udf_clr_prio got %b exp 0", udf); end
        brnch = 1; res_vld = 1;
        tick();
        brnch = 0; res_vld = 0;
        checks++; if (udf !== 1'b1 || empty !== 1'b0) begin errors++; $display("FAIL udf_empty_pushpop got udf=%b empty=%b exp 1 0", udf, empty); end
        $display("underflow: udf=%b empty=%b", udf, empty);
    endtask

    task automatic test_mispred_sat;
        logic mp, sh;
        apply_reset();
        for (int i = 0; i < 260; i++) begin
            do_branch(4'h3 ^ ghr_m, (i % 2) == 0, mp, sh);
            if (i == 253) begin
                checks++; if (mispred_cnt !== 8'hFE) begin errors++; $display("FAIL cnt_254 got %h exp fe", mispred_cnt); end
            end
        end
        checks++; if (mispred_cnt !== 8'hFF) begin errors++; $display("FAIL cnt_sat got %h exp ff", mispred_cnt); end
        $display("mispred sat: cnt=%h", mispred_cnt);
        brnch = 1; adrs = 4'h3 ^ ghr_m;
        tick();
        brnch = 0; res_vld = 1; res_taken = 1; clr = 1;
        tick();
        res_vld = 0; clr = 0;
        checks++; if (mispred_cnt !== 8'h00 || mispred !== 1'b1) begin errors++; $display("FAIL cnt_clr got cnt=%h mp=%b exp 00 1", mispred_cnt, mispred); end
    endtask

    task automatic test_reset_mid;
        logic mp, sh;
        apply_reset();
        do_branch(4'h5, 1'b1, mp, sh);
        brnch = 1; adrs = 4'h2;
        tick(); tick();
        brnch = 0;
        checks++; if (empty !== 1'b0 || sram !== 16'h0020) begin errors++; $display("FAIL rstmid_pre got empty=%b sram=%h exp 0 0020", empty, sram); end
        #2 rst = 1;
        #1;
        checks++; if (empty !== 1'b1 || full !== 1'b0 || sram !== 16'h0000)
            begin errors++; $display("FAIL rstmid_async got empty=%b full=%b sram=%h exp 1 0 0000", empty, full, sram); end
        $display("reset mid: empty=%b sram=%h", empty, sram);
        tick();
        rst = 0;
        tick();
    endtask

    initial begin
        rst = 1; brnch = 0; adrs = 0; res_vld = 0; res_taken = 0; clr = 0;
        ghr_m = 4'h0;
        test_reset();
        test_train();
        test_saturation();
        test_full();
        test_underflow();
        test_mispred_sat();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
